// File: rtl/cdc_pkg.sv
// Shared helpers for the async FIFO read-side logic: depth legality, pointer sizing
// and the default-width stream beat type.
package cdc_pkg;

  localparam int STREAM_DATA_W = 8;

  typedef struct packed {
    logic [STREAM_DATA_W-1:0] data;
  } stream_beat_t;

  function automatic bit buf_depth_ok(input int depth);
    return (depth >= 2) && (depth <= 8);
  endfunction

  // Never returns 0 so a depth of 1 or 2 still yields a usable 1-bit pointer.
  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/stream_circ_buf.sv
// Small circular buffer with head-of-queue output; pointers wrap explicitly so any
// depth 2..8 works, not only powers of two.
module stream_circ_buf
  import cdc_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 3,
  localparam int PTR_W     = ptr_width(BUF_DEPTH),
  localparam int OCC_W     = ptr_width(BUF_DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  output logic [OCC_W-1:0]      occ_o,
  output logic [DATA_WIDTH-1:0] head_o
);

  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [BUF_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic                  do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_push = push_i & ~flush_i;
  assign do_pop  = pop_i & ~flush_i;

  for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
    assign mem_d[gi] = (do_push && (wr_ptr_q == PTR_W'(gi))) ? push_data_i : mem_q[gi];
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      // Push and pop together leave the occupancy unchanged.
      if (do_push && !do_pop)      occ_d = occ_q + OCC_W'(1);
      else if (do_pop && !do_push) occ_d = occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign occ_o  = occ_q;
  assign head_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/async_fifo_rd_stream.sv
// Read-side adapter for the async FIFO: drains the rrdy/reb read port into a
// valid/ready stream, hiding the 1-cycle read latency behind a credit-tracked buffer.
module async_fifo_rd_stream
  import cdc_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  fifo_rrdy_i,
  input  logic [DATA_WIDTH-1:0] fifo_doutb_i,
  output logic                  fifo_reb_o,
  input  logic                  flush_i,
  output logic                  m_valid_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  input  logic                  m_ready_i,
  output logic [CNT_WIDTH-1:0]  count_o
);

  localparam int OCC_W = ptr_width(BUF_DEPTH + 1);

  if (!buf_depth_ok(BUF_DEPTH)) begin : g_bad_depth
    $error("async_fifo_rd_stream: BUF_DEPTH must be in 2..8");
  end

  logic                 run_q, run_d;
  logic                 inflight_q, inflight_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [OCC_W-1:0]     occ;
  logic                 credit_ok;
  logic                 push, pop;

  // Credits count both buffered words and the word still on its way from the FIFO.
  assign credit_ok = (int'(occ) + int'(inflight_q)) < BUF_DEPTH;

  // run_q keeps reb low while reset is held, even with rrdy already high.
  assign fifo_reb_o = run_q & fifo_rrdy_i & ~flush_i & credit_ok;
  assign m_valid_o  = (occ != '0);
  assign push       = inflight_q & ~flush_i;
  assign pop        = m_valid_o & m_ready_i & ~flush_i;

  stream_circ_buf #(
    .DATA_WIDTH(DATA_WIDTH),
    .BUF_DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (push),
    .push_data_i(fifo_doutb_i),
    .pop_i      (pop),
    .flush_i    (flush_i),
    .occ_o      (occ),
    .head_o     (m_data_o)
  );

  always_comb begin
    run_d      = 1'b1;
    inflight_d = fifo_reb_o;
    count_d    = count_q;
    if (pop) count_d = count_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q      <= 1'b0;
      inflight_q <= 1'b0;
      count_q    <= '0;
    end else begin
      run_q      <= run_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: tb/tb_async_fifo_rd_stream.sv
// Bench for async_fifo_rd_stream: four lanes (depth 3, 2, 5 and a 4-bit counter lane)
// each fed by a FIFO model and checked every cycle against a queue-based reference.
module tb_async_fifo_rd_stream;
  import cdc_pkg::*;

  localparam int NL = 4;

  function automatic int lane_depth(input int l);
    case (l)
      1:       return 2;
      2:       return 5;
      default: return 3;
    endcase
  endfunction

  function automatic int lane_cw(input int l);
    return (l == 3) ? 4 : 16;
  endfunction

  logic clk = 1'b0;
  logic rst_n;
  logic [NL-1:0]       rrdy, ready, flush;
  logic [NL-1:0][7:0]  doutb;
  logic [NL-1:0]       reb_w, valid_w;
  logic [NL-1:0][7:0]  data_w;
  logic [NL-1:0][15:0] cnt_w;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NL; gi++) begin : g_lane
    localparam int D  = lane_depth(gi);
    localparam int CW = lane_cw(gi);
    logic [CW-1:0] cnt_l;
    async_fifo_rd_stream #(.DATA_WIDTH(8), .BUF_DEPTH(D), .CNT_WIDTH(CW)) u_dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .fifo_rrdy_i (rrdy[gi]),
      .fifo_doutb_i(doutb[gi]),
      .fifo_reb_o  (reb_w[gi]),
      .flush_i     (flush[gi]),
      .m_valid_o   (valid_w[gi]),
      .m_data_o    (data_w[gi]),
      .m_ready_i   (ready[gi]),
      .count_o     (cnt_l)
    );
    assign cnt_w[gi] = 16'(cnt_l);
  end

  // Reference state: source FIFO contents, buffered words, in-flight flag, counter.
  logic [7:0]   src [NL][$];
  stream_beat_t mq  [NL][$];
  bit           infl_m [NL];
  bit           reb_s  [NL];
  bit           gate   [NL];
  int           cnt_m  [NL];
  int           est    [NL];
  int           beats  [NL];
  int           reads  [NL];
  int           first_cyc [NL];
  int           cyc16  [NL];
  logic [7:0]   last_data [NL];
  logic [7:0]   next_word [NL];
  bit           run_m = 1'b0;
  bit           seq_on = 1'b0;
  int           cyc = 0;
  int           first_reb = -1, first_valid = -1;
  int           n_total = 0, n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_step();
    for (int l = 0; l < NL; l++) begin
      bit exp_reb, exp_valid;
      exp_reb   = run_m && rrdy[l] && !flush[l] &&
                  ((mq[l].size() + int'(infl_m[l])) < lane_depth(l));
      exp_valid = (mq[l].size() != 0);
      reb_s[l]  = reb_w[l];
      check_eq($sformatf("reb%0d", l), 32'(reb_w[l]), 32'(exp_reb));
      check_eq($sformatf("valid%0d", l), 32'(valid_w[l]), 32'(exp_valid));
      if (exp_valid) check_eq($sformatf("data%0d", l), 32'(data_w[l]), 32'(mq[l][0].data));
      check_eq($sformatf("count%0d", l), 32'(cnt_w[l]), 32'(cnt_m[l]));
      check_eq($sformatf("credit%0d", l), 32'(est[l] <= lane_depth(l)), 32'd1);
      if (!rst_n) begin
        mq[l].delete();
        infl_m[l] = 1'b0;
        cnt_m[l]  = 0;
        est[l]    = 0;
        reb_s[l]  = 1'b0;
      end else if (flush[l]) begin
        mq[l].delete();
        infl_m[l] = 1'b0;
        est[l]    = 0;
      end else begin
        if (l == 0 && first_reb < 0 && reb_w[0]) first_reb = cyc;
        if (l == 0 && first_valid < 0 && valid_w[0]) first_valid = cyc;
        if (reb_w[l]) begin
          est[l]++;
          reads[l]++;
        end
        if (valid_w[l] && ready[l]) est[l]--;
        if (exp_valid && ready[l]) begin
          if (l == 0 && seq_on) check_eq("seq", 32'(data_w[0]), 32'(beats[0] + 1));
          if (beats[l] == 0)  first_cyc[l] = cyc;
          if (beats[l] == 15) cyc16[l] = cyc;
          last_data[l] = mq[l][0].data;
          void'(mq[l].pop_front());
          cnt_m[l] = (cnt_m[l] + 1) % (1 << lane_cw(l));
          beats[l]++;
        end
        if (infl_m[l]) mq[l].push_back(stream_beat_t'{data: doutb[l]});
        infl_m[l] = exp_reb;
      end
    end
    run_m = rst_n;
  endtask

  task automatic tick();
    for (int l = 0; l < NL; l++) rrdy[l] = gate[l] && (src[l].size() != 0);
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    for (int l = 0; l < NL; l++)
      if (reb_s[l] && src[l].size() != 0) doutb[l] = src[l].pop_front();
    cyc++;
  endtask

  task automatic push_words(input int n);
    for (int l = 0; l < NL; l++)
      for (int k = 0; k < n; k++) begin
        src[l].push_back(next_word[l]);
        next_word[l] = next_word[l] + 8'd1;
      end
  endtask

  function automatic bit all_beats(input int n);
    for (int l = 0; l < NL; l++) if (beats[l] < n) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit all_idle();
    for (int l = 0; l < NL; l++)
      if (src[l].size() != 0 || mq[l].size() != 0 || infl_m[l]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain(input string tag);
    for (int l = 0; l < NL; l++) begin
      gate[l] = 1'b1;
      ready[l] = 1'b1;
      flush[l] = 1'b0;
    end
    for (int i = 0; i < 200 && !all_idle(); i++) tick();
    tick();
    check_eq(tag, 32'(all_idle()), 32'd1);
    check_eq({tag, "_valid"}, 32'(valid_w), 32'd0);
  endtask

  initial begin
    int c0, base;
    int rd0 [NL];
    int tgt [NL];
    bit done;
    rst_n = 1'b0;
    rrdy = '0; ready = '0; flush = '0; doutb = '0;
    for (int l = 0; l < NL; l++) begin
      gate[l] = 1'b1;
      ready[l] = 1'b1;
      next_word[l] = 8'h01;
      beats[l] = 0;
      reads[l] = 0;
    end
    push_words(16);

    // Reset held with rrdy high, then released.
    repeat (3) tick();
    check_eq("rst_reb", 32'(reb_w[0]), 32'd0);
    check_eq("rst_valid", 32'(valid_w[0]), 32'd0);
    check_eq("rst_data", 32'(data_w[0]), 32'd0);
    check_eq("rst_count", 32'(cnt_w[0]), 32'd0);
    rst_n = 1'b1;
    seq_on = 1'b1;
    c0 = cyc;
    $display("reset released at cycle %0d", c0);

    // Streaming 0x01..0x10 with ready held high.
    for (int i = 0; i < 60 && !all_beats(16); i++) tick();
    check_eq("first_reb", 32'(first_reb - c0), 32'd1);
    check_eq("first_valid", 32'(first_valid - c0), 32'd3);
    check_eq("stream_n", 32'(all_beats(16)), 32'd1);
    check_eq("stream_span_d3", 32'(cyc16[0] - first_cyc[0]), 32'd15);
    check_eq("stream_span_d5", 32'(cyc16[2] - first_cyc[2]), 32'd15);
    check_eq("stream_span_d2", 32'(cyc16[1] - first_cyc[1]), 32'd22);
    check_eq("stream_count", 32'(cnt_w[0]), 32'd16);
    check_eq("wrap_count16", 32'(cnt_w[3]), 32'd0);
    $display("streamed 16 words, count0=%0d count3=%0d", cnt_w[0], cnt_w[3]);

    push_words(1);
    for (int i = 0; i < 20 && !all_beats(17); i++) tick();
    check_eq("count17", 32'(cnt_w[0]), 32'd17);
    check_eq("wrap_count17", 32'(cnt_w[3]), 32'd1);
    seq_on = 1'b0;
    $display("17th word delivered, count3=%0d", cnt_w[3]);

    // Backpressure: ready low for 10 cycles while rrdy stays high.
    for (int l = 0; l < NL; l++) begin
      ready[l] = 1'b0;
      rd0[l] = reads[l];
    end
    push_words(20);
    repeat (3) tick();
    check_eq("bp_valid_early", 32'(valid_w[0]), 32'd1);
    check_eq("bp_head_early", 32'(data_w[0]), 32'd18);
    repeat (7) tick();
    for (int l = 0; l < NL; l++)
      check_eq($sformatf("bp_reads%0d", l), 32'(reads[l] - rd0[l]), 32'(lane_depth(l)));
    check_eq("bp_reb", 32'(reb_w[0]), 32'd0);
    check_eq("bp_valid", 32'(valid_w[0]), 32'd1);
    check_eq("bp_head", 32'(data_w[0]), 32'd18);
    drain("bp_drain");
    check_eq("bp_count", 32'(cnt_w[0]), 32'd37);
    $display("backpressure released, count0=%0d", cnt_w[0]);

    // Flush one cycle after a read with two words buffered.
    for (int l = 0; l < NL; l++) begin
      ready[l] = 1'b0;
      next_word[l] = 8'hA0;
    end
    push_words(8);
    repeat (3) tick();
    for (int l = 0; l < NL; l++) flush[l] = 1'b1;
    tick();
    for (int l = 0; l < NL; l++) begin
      flush[l] = 1'b0;
      ready[l] = 1'b1;
    end
    check_eq("flush_valid", 32'(valid_w), 32'd0);
    check_eq("flush_count", 32'(cnt_w[0]), 32'd37);
    base = beats[0];
    for (int i = 0; i < 20 && beats[0] == base; i++) tick();
    check_eq("flush_next", 32'(last_data[0]), 32'hA3);
    drain("flush_drain");
    $display("flush done, next word after flush 0x%0h", last_data[0]);

    // Random ready, rrdy, supply and rare flushes until every lane has 10k more words.
    for (int l = 0; l < NL; l++) tgt[l] = beats[l] + 10000;
    done = 1'b0;
    for (int i = 0; i < 60000 && !done; i++) begin
      for (int l = 0; l < NL; l++) begin
        gate[l]  = ($urandom_range(0, 3) != 0);
        ready[l] = ($urandom_range(0, 3) != 0);
        flush[l] = ($urandom_range(0, 499) == 0);
        if (src[l].size() < 16 && $urandom_range(0, 3) != 0) begin
          src[l].push_back(next_word[l]);
          next_word[l] = next_word[l] + 8'd1;
        end
      end
      tick();
      done = 1'b1;
      for (int l = 0; l < NL; l++) if (beats[l] < tgt[l]) done = 1'b0;
    end
    for (int l = 0; l < NL; l++)
      check_eq($sformatf("rnd_words%0d", l), 32'(beats[l] >= tgt[l]), 32'd1);
    drain("rnd_drain");
    $display("random phase done at cycle %0d", cyc);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
